// File: rtl/timer_periph_multi.sv
// Bus peripheral with N_TIMERS reload timers, LED/digit output registers,
// a synchronised switch input and sticky W1C timer interrupt status.
module timer_periph_multi #(
    parameter int          N_TIMERS  = 2,
    parameter int          TW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [LED_W-1:0]    led,
    input  logic [SW_W-1:0]     switch,
    output logic [DIGI_W-1:0]   digi,
    output logic [N_TIMERS-1:0] irq_vec,
    output logic                irqout
);

    logic [TW-1:0] th_q   [N_TIMERS];
    logic [TW-1:0] th_d   [N_TIMERS];
    logic [TW-1:0] tl_q   [N_TIMERS];
    logic [TW-1:0] tl_d   [N_TIMERS];
    logic [TW-1:0] pre_q  [N_TIMERS];
    logic [TW-1:0] pre_d  [N_TIMERS];
    logic [TW-1:0] pcnt_q [N_TIMERS];
    logic [TW-1:0] pcnt_d [N_TIMERS];
    logic [N_TIMERS-1:0] en_q, en_d;
    logic [N_TIMERS-1:0] irq_en_q, irq_en_d;
    logic [N_TIMERS-1:0] oneshot_q, oneshot_d;
    logic [N_TIMERS-1:0] irqstat_q, irqstat_d;
    logic [N_TIMERS-1:0] irq_set;

    logic [LED_W-1:0]  led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

    logic [31:0] off;
    logic        hit;
    logic        tmr_area;

    // Window is 0x00..0x4F from the base; only word-aligned offsets decode.
    assign off      = addr - BASE_ADDR;
    assign hit      = (off < 32'h50) && (off[1:0] == 2'b00);
    assign tmr_area = (off < 32'h40);

    always_comb begin
        logic sel, tick, ovf;
        logic w_th, w_tl, w_tcon, w_pre;
        irq_set = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            sel    = wr && hit && tmr_area && (off[5:4] == 2'(i));
            w_th   = sel && (off[3:2] == 2'd0);
            w_tl   = sel && (off[3:2] == 2'd1);
            w_tcon = sel && (off[3:2] == 2'd2);
            w_pre  = sel && (off[3:2] == 2'd3);

            tick = en_q[i] && (pcnt_q[i] == pre_q[i]);
            // A bus write to TL discards any overflow on the same edge.
            ovf  = tick && (tl_q[i] == '1) && !w_tl;

            th_d[i]  = w_th  ? wdata[TW-1:0] : th_q[i];
            pre_d[i] = w_pre ? wdata[TW-1:0] : pre_q[i];

            if (w_tl)
                tl_d[i] = wdata[TW-1:0];
            else if (tick)
                tl_d[i] = (tl_q[i] == '1) ? th_q[i] : tl_q[i] + 1'b1;
            else
                tl_d[i] = tl_q[i];

            if (w_tcon)
                pcnt_d[i] = '0;
            else if (en_q[i])
                pcnt_d[i] = tick ? '0 : pcnt_q[i] + 1'b1;
            else
                pcnt_d[i] = pcnt_q[i];

            if (w_tcon) begin
                en_d[i]      = wdata[0];
                irq_en_d[i]  = wdata[1];
                oneshot_d[i] = wdata[2];
            end else begin
                en_d[i]      = (ovf && oneshot_q[i]) ? 1'b0 : en_q[i];
                irq_en_d[i]  = irq_en_q[i];
                oneshot_d[i] = oneshot_q[i];
            end

            irq_set[i] = ovf && irq_en_q[i];
        end
    end

    always_comb begin
        logic g_sel;
        logic [N_TIMERS-1:0] clr;
        g_sel  = wr && hit && !tmr_area;
        led_d  = (g_sel && off[3:2] == 2'd0) ? wdata[LED_W-1:0]  : led_q;
        digi_d = (g_sel && off[3:2] == 2'd2) ? wdata[DIGI_W-1:0] : digi_q;
        clr    = (g_sel && off[3:2] == 2'd3) ? wdata[N_TIMERS-1:0] : '0;
        // A new overflow beats a simultaneous clear.
        irqstat_d = irq_set | (irqstat_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                th_q[i]   <= '0;
                tl_q[i]   <= '0;
                pre_q[i]  <= '0;
                pcnt_q[i] <= '0;
            end
            en_q      <= '0;
            irq_en_q  <= '0;
            oneshot_q <= '0;
            irqstat_q <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            for (int i = 0; i < N_TIMERS; i++) begin
                th_q[i]   <= th_d[i];
                tl_q[i]   <= tl_d[i];
                pre_q[i]  <= pre_d[i];
                pcnt_q[i] <= pcnt_d[i];
            end
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            oneshot_q <= oneshot_d;
            irqstat_q <= irqstat_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            if (tmr_area) begin
                for (int i = 0; i < N_TIMERS; i++) begin
                    if (off[5:4] == 2'(i)) begin
                        case (off[3:2])
                            2'd0:    rdata = 32'(th_q[i]);
                            2'd1:    rdata = 32'(tl_q[i]);
                            2'd2:    rdata = {29'd0, oneshot_q[i], irq_en_q[i], en_q[i]};
                            default: rdata = 32'(pre_q[i]);
                        endcase
                    end
                end
            end else begin
                case (off[3:2])
                    2'd0:    rdata = 32'(led_q);
                    2'd1:    rdata = 32'(sw_sync_q);
                    2'd2:    rdata = 32'(digi_q);
                    default: rdata = 32'(irqstat_q);
                endcase
            end
        end
    end

    assign led     = led_q;
    assign digi    = digi_q;
    assign irq_vec = irqstat_q;
    assign irqout  = |irqstat_q;

endmodule

// File: tb/tb_timer_periph_multi.sv
// Directed bench for timer_periph_multi: expected read data is queued when a
// read is issued and popped/compared when rdata is sampled.
`timescale 1ns/10ps
module tb_timer_periph_multi;

    localparam logic [31:0] B = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  led;
    logic [7:0]  switch;
    logic [11:0] digi;
    logic [1:0]  irq_vec;
    logic        irqout;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    timer_periph_multi dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .led(led), .switch(switch),
        .digi(digi), .irq_vec(irq_vec), .irqout(irqout)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        $display("wr addr=%h data=%h", a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        addr = a; rd = 1'b1;
        #1;
        e = exp_q.pop_front();
        chk(tag, rdata, e);
        $display("rd %s addr=%h data=%h", tag, a, rdata);
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; switch = '0;
        step(2);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(irq_vec), 32'h0);
        rd_chk("rst_tl0", B + 32'h04, 32'h0);
        reset = 1'b1;
        step(1);

        // Decode and simple I/O
        bus_wr(B + 32'h40, 32'hA5);
        chk("led", 32'(led), 32'hA5);
        bus_wr(B + 32'h48, 32'hABC);
        chk("digi", 32'(digi), 32'hABC);
        bus_wr(B + 32'h41, 32'hFF);
        chk("mis_wr", 32'(led), 32'hA5);
        rd_chk("mis_rd", B + 32'h41, 32'h0);
        rd_chk("led_rd", B + 32'h40, 32'hA5);
        bus_wr(B + 32'h20, 32'h1234);
        rd_chk("slot2", B + 32'h20, 32'h0);
        rd_chk("outside", B + 32'h50, 32'h0);
        addr = B + 32'h40; rd = 1'b0; #1;
        chk("rd_low", rdata, 32'h0);
        switch = 8'h3C;
        step(1);
        rd_chk("sw_1clk", B + 32'h44, 32'h0);
        step(1);
        rd_chk("sw_2clk", B + 32'h44, 32'h3C);

        // Auto-reload with IRQ on timer0
        bus_wr(B + 32'h00, 32'hFFFFFFFD);
        bus_wr(B + 32'h04, 32'hFFFFFFFD);
        bus_wr(B + 32'h0C, 32'h0);
        bus_wr(B + 32'h08, 32'h3);
        rd_chk("ar_tl0", B + 32'h04, 32'hFFFFFFFD);
        step(1);
        rd_chk("ar_tl1", B + 32'h04, 32'hFFFFFFFE);
        step(1);
        rd_chk("ar_tl2", B + 32'h04, 32'hFFFFFFFF);
        chk("ar_irq_pre", 32'(irq_vec), 32'h0);
        step(1);
        rd_chk("ar_tl3", B + 32'h04, 32'hFFFFFFFD);
        chk("ar_irq", 32'(irq_vec), 32'h1);
        chk("ar_irqout", 32'(irqout), 32'h1);
        step(1);
        rd_chk("ar_tl4", B + 32'h04, 32'hFFFFFFFE);
        chk("ar_sticky", 32'(irq_vec), 32'h1);
        bus_wr(B + 32'h4C, 32'h1);
        rd_chk("w1c_stat", B + 32'h4C, 32'h0);
        chk("w1c_irqout", 32'(irqout), 32'h0);
        bus_wr(B + 32'h4C, 32'h1);
        rd_chk("coll_w1c_tl", B + 32'h04, 32'hFFFFFFFD);
        rd_chk("coll_w1c_stat", B + 32'h4C, 32'h1);
        bus_wr(B + 32'h08, 32'h0);
        rd_chk("stop_tcon", B + 32'h08, 32'h0);
        step(3);
        rd_chk("frozen_tl", B + 32'h04, 32'hFFFFFFFE);

        // TL write colliding with an overflow
        bus_wr(B + 32'h4C, 32'h1);
        bus_wr(B + 32'h04, 32'hFFFFFFFF);
        bus_wr(B + 32'h08, 32'h3);
        bus_wr(B + 32'h04, 32'h1234);
        rd_chk("coll_tl", B + 32'h04, 32'h1234);
        rd_chk("coll_tl_irq", B + 32'h4C, 32'h0);
        step(1);
        rd_chk("coll_tl_next", B + 32'h04, 32'h1235);
        bus_wr(B + 32'h08, 32'h0);

        // One-shot on timer0
        bus_wr(B + 32'h00, 32'h5);
        bus_wr(B + 32'h04, 32'hFFFFFFFF);
        bus_wr(B + 32'h08, 32'h7);
        rd_chk("os_tl0", B + 32'h04, 32'hFFFFFFFF);
        step(1);
        rd_chk("os_tl1", B + 32'h04, 32'h5);
        rd_chk("os_tcon", B + 32'h08, 32'h6);
        rd_chk("os_stat", B + 32'h4C, 32'h1);
        step(1);
        rd_chk("os_hold", B + 32'h04, 32'h5);

        // Prescaler on timer1
        bus_wr(B + 32'h1C, 32'h3);
        bus_wr(B + 32'h14, 32'h0);
        bus_wr(B + 32'h18, 32'h1);
        step(3);
        rd_chk("pre_3clk", B + 32'h14, 32'h0);
        step(1);
        rd_chk("pre_4clk", B + 32'h14, 32'h1);
        step(2);
        bus_wr(B + 32'h18, 32'h1);
        step(3);
        rd_chk("pre_restart3", B + 32'h14, 32'h1);
        step(1);
        rd_chk("pre_restart4", B + 32'h14, 32'h2);

        // Reset asserted mid-count
        reset = 1'b0;
        #1;
        chk("mrst_led", 32'(led), 32'h0);
        chk("mrst_digi", 32'(digi), 32'h0);
        chk("mrst_irq", 32'(irq_vec), 32'h0);
        chk("mrst_irqout", 32'(irqout), 32'h0);
        rd_chk("mrst_tl1", B + 32'h14, 32'h0);
        rd_chk("mrst_tl0", B + 32'h04, 32'h0);
        #2;
        reset = 1'b1;
        step(2);
        rd_chk("post_tl1", B + 32'h14, 32'h0);
        rd_chk("post_tcon1", B + 32'h18, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
